if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction fetch stage with PC register and single-outstanding request/response fetch from instruction memory.
- Owns the IF/ID pipeline register that presents `id_inst`/`id_pc` to decode.
- Decode feeds `id_inst` to the immediate generator and register file.
- Accepts a redirect from execute for taken branches and jumps, flushing the IF/ID register and any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INST, 32'h0000_0013 (addi x0,x0,0), value driven on `id_inst` when flushed or at reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address, word aligned
- imem_gnt  input  1  memory accepts request this cycle
- imem_rvalid  input  1  read data valid; earliest is the cycle after `imem_gnt`
- imem_rdata  input  32  fetched instruction
- id_valid  output  1  IF/ID register holds a valid instruction
- id_ready  input  1  decode consumes the instruction this cycle
- id_inst  output  32  instruction to decode
- id_pc  output  32  PC of `id_inst`
- redirect_valid  input  1  taken branch/jump from execute
- redirect_pc  input  32  target PC; bits [1:0] ignored and forced to 0
- perf_starve_cnt  output  32  fetch-starvation counter (see Optional Feature)

Behaviour:
- Reset (async, `rst_n`=0):
  - Registers: pc=RESET_PC, state=REQ.
  - Outputs: `imem_req`=0, `imem_addr`=RESET_PC, `id_valid`=0, `id_inst`=NOP_INST, `id_pc`=0, `perf_starve_cnt`=0.
  - Reset mid-transaction abandons the transaction. Memory must drop it too; no response is expected after reset.
- States: REQ, WAIT, DROP.
- REQ:
  - `imem_addr`=pc.
  - `imem_req` = (!`id_valid` || `id_ready`). The slot must be free or freeing before a fetch issues.
  - `imem_addr` is held stable while `imem_req` && !`imem_gnt`.
  - On `imem_req` && `imem_gnt` -> WAIT.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`: `id_inst`<=`imem_rdata`, `id_pc`<=pc, `id_valid`<=1, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) -> REQ.
- DROP:
  - `imem_req`=0.
  - The next `imem_rvalid` is discarded (no IF/ID update) -> REQ.
- Consume: `id_ready` && `id_valid` && no load this cycle -> `id_valid`<=0 and `id_inst`<=NOP_INST.
  - Load and consume in the same cycle is a pass-through: the new instruction is loaded and `id_valid` stays 1.
- Hold: while `id_valid` && !`id_ready`, `id_inst`/`id_pc` are stable.
- Redirect has highest priority, in any state:
  - pc<={`redirect_pc`[31:2],2'b00}; `id_valid`<=0; `id_inst`<=NOP_INST.
  - REQ without grant this cycle -> stay REQ. The next request uses the new pc.
  - REQ with grant this cycle -> DROP.
  - WAIT without `imem_rvalid` -> DROP.
  - WAIT with `imem_rvalid` same cycle -> data discarded -> REQ.
  - DROP -> stay DROP, pc updated.
- Throughput: at most one instruction per 2 cycles (REQ, then response). Latency from grant to `id_valid` = memory latency + 1 cycle.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: `perf_starve_cnt` increments each cycle `id_ready`=1 && `id_valid`=0 (decode starved). It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Undefined: counter logic is absent and `perf_starve_cnt` is tied to 0.

Test Plan:
- Reset release, memory with 1-cycle latency, `id_ready`=1 -> first `imem_addr`=0x0; `id_pc` sequence 0x0, 0x4, 0x8 on every second cycle; `id_inst` matches memory contents.
- `id_ready`=0 for 5 cycles with `id_valid`=1 (`id_inst`=0x00500093) -> `imem_req` stays 0; `id_inst`/`id_pc` stable; fetch of pc+4 issues in the cycle `id_ready` returns to 1.
- `redirect_valid` with `redirect_pc`=0x0000_0103 while in WAIT, rvalid 2 cycles later -> stale data dropped; next `imem_addr`=0x100; next `id_pc`=0x100; `id_valid` is 0 in between.
- Redirect in the same cycle as `imem_rvalid` -> no `id_valid` pulse for the stale data; next request address equals the redirect target.
- RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0000_0000 (wrap).
- `rst_n` low while in WAIT, then released -> all outputs at reset values; next request at RESET_PC. With IF_PERF_CNT_EN, 3 starved cycles -> `perf_starve_cnt`=3.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, one outstanding imem request, IF/ID register.
// Optional IF_PERF_CNT_EN macro enables the decode-starvation counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] perf_starve_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] idpc_q, idpc_d;
  logic        fire;
  logic        load;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      inst_q  <= NOP_INST;
      idpc_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      inst_q  <= inst_d;
      idpc_q  <= idpc_d;
    end
  end

  // A response in DROP always returns to REQ, even under a new redirect, so we never wait on a response that will not come.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (fire) state_d = redirect_valid ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)         state_d = S_REQ;
        else if (redirect_valid) state_d = S_DROP;
      end
      S_DROP:  if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    imem_req  = rst_n && (state_q == S_REQ) && (!vld_q || id_ready);
    imem_addr = pc_q;
    id_valid  = vld_q;
    id_inst   = inst_q;
    id_pc     = idpc_q;
  end

  assign fire = imem_req && imem_gnt;
  assign load = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;

  always_comb begin
    pc_d   = pc_q;
    vld_d  = vld_q;
    inst_d = inst_q;
    idpc_d = idpc_q;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      vld_d  = 1'b0;
      inst_d = NOP_INST;
    end else if (load) begin
      pc_d   = pc_q + 32'd4;
      vld_d  = 1'b1;
      inst_d = imem_rdata;
      idpc_d = pc_q;
    end else if (vld_q && id_ready) begin
      vld_d  = 1'b0;
      inst_d = NOP_INST;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] starve_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 32'h0;
    end else if (id_ready && !vld_q && (starve_q != 32'hFFFF_FFFF)) begin
      starve_q <= starve_q + 32'd1;
    end
  end

  assign perf_starve_cnt = starve_q;
`else
  assign perf_starve_cnt = 32'h0;
`endif

endmodule
